alu_exec_unit: RTL and testbench



---
 rtl/cpu_alu_pkg.sv | 25 ++
 rtl/alu_exec_unit_seq_multiplier.sv | 75 +++++++
 rtl/alu_exec_unit.sv | 103 ++++++++++
 tb/tb_alu_exec_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_alu_pkg.sv
// Shared ALU constants: op encodings, default widths and the MUL sequencer states.
package cpu_alu_pkg;

  localparam int unsigned ALU_WIDTH = 24;
  localparam int unsigned ALU_SHW   = 5;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLT = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } mul_state_t;

  // Opcodes 0000..0110 are implemented; anything above is flagged illegal.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_SLL);
  endfunction

endpackage

// File: rtl/alu_exec_unit_seq_multiplier.sv
// Shift-add sequential multiplier: WIDTH iterations, 2*WIDTH-bit accumulator.
// 'last' marks the final iteration; 'product' is the accumulator value after it.
module seq_multiplier
  import cpu_alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mul_state_t         state, state_nx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] ma;
  logic [WIDTH-1:0]   mb;
  logic [2*WIDTH-1:0] acc_step;

  // Next state, per-iteration accumulate, and final-iteration detect.
  always_comb begin
    state_nx = state;
    last     = 1'b0;
    acc_step = mb[0] ? (acc + ma) : acc;
    case (state)
      ST_IDLE: if (start) state_nx = ST_MUL;
      ST_MUL: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last     = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register; reset aborts any multiply in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Operand/accumulator/counter datapath: load on start, step while in ST_MUL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
      ma  <= '0;
      mb  <= '0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        cnt <= '0;
        acc <= '0;
        ma  <= {{WIDTH{1'b0}}, a};
        mb  <= b;
      end
    end else begin
      acc <= acc_step;
      ma  <= ma << 1;
      mb  <= mb >> 1;
      cnt <= cnt + CW'(1);
    end
  end

  assign busy    = (state == ST_MUL);
  assign product = acc_step;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus a multi-cycle MUL
// behind a start/busy/done handshake. All result and flag outputs are registered.
module alu_exec_unit
  import cpu_alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned SHW   = ALU_SHW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Operation,
  input  logic             Bnegate,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  logic               accept;
  logic               mul_start;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH-1:0]   res_c;
  logic               ovf_c;
  logic               ill_c;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH-1:0]   addsub;
  logic [WIDTH-1:0]   diff;
  logic               slt_ovf;
  logic [31:0]        shamt;

  assign accept    = start & ~busy;
  assign mul_start = accept && (Operation == OP_MUL);

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (A),
    .b       (B),
    .busy    (busy),
    .last    (mul_last),
    .product (mul_product)
  );

  // Combinational op mux for every single-cycle op.
  always_comb begin
    res_c   = '0;
    ovf_c   = 1'b0;
    ill_c   = ~is_legal_op(Operation);
    b_eff   = Bnegate ? ~B : B;
    addsub  = A + b_eff + WIDTH'(Bnegate);
    diff    = A - B;
    slt_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
    shamt   = 32'(B[SHW-1:0]);
    case (Operation)
      OP_AND: res_c = A & B;
      OP_OR:  res_c = A | B;
      OP_ADD: begin
        res_c = addsub;
        ovf_c = (A[WIDTH-1] == b_eff[WIDTH-1]) && (addsub[WIDTH-1] != A[WIDTH-1]);
      end
      // Sign of A-B corrected by its overflow gives the true signed compare.
      OP_SLT: res_c = WIDTH'(diff[WIDTH-1] ^ slt_ovf);
      OP_XOR: res_c = A ^ B;
      OP_SLL: res_c = (shamt >= 32'(WIDTH)) ? '0 : (A << shamt);
      default: res_c = '0;
    endcase
  end

  // Result/flag registers: loaded on a single-cycle accept or on the final MUL step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Result   <= '0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      if (mul_last) begin
        Result   <= mul_product[WIDTH-1:0];
        Zero     <= (mul_product[WIDTH-1:0] == '0);
        Overflow <= |mul_product[2*WIDTH-1:WIDTH];
        done     <= 1'b1;
      end else if (accept && (Operation != OP_MUL)) begin
        Result   <= res_c;
        Zero     <= (res_c == '0);
        Overflow <= ovf_c;
        illegal  <= ill_c;
        done     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with an expected-result scoreboard.
module tb_alu_exec_unit;
  import cpu_alu_pkg::*;

  localparam int unsigned W = 24;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [3:0]   Operation = '0;
  logic         Bnegate = 1'b0;
  logic [W-1:0] Result;
  logic         Zero, Overflow, busy, done, illegal;

  alu_exec_unit #(.WIDTH(W), .SHW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .A         (A),
    .B         (B),
    .Operation (Operation),
    .Bnegate   (Bnegate),
    .Result    (Result),
    .Zero      (Zero),
    .Overflow  (Overflow),
    .busy      (busy),
    .done      (done),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [W-1:0] res;
    logic         z;
    logic         o;
    logic         il;
    int           lat;
    int           bcyc;
  } exp_t;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fail    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic bn, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    Operation = op;
    Bnegate   = bn;
    A         = a;
    B         = b;
    start     = 1'b1;
  endtask

  task automatic push(input string tag, input logic [W-1:0] r, input logic z,
                      input logic o, input logic il, input int lat, input int bcyc);
    exp_t e;
    e.tag = tag; e.res = r; e.z = z; e.o = o; e.il = il; e.lat = lat; e.bcyc = bcyc;
    sb.push_back(e);
  endtask

  // Called just after the accepting edge; waits (bounded) for done, then scores it.
  task automatic collect(input bit inject);
    int   edges = 0;
    int   bc    = 0;
    exp_t e;
    while (!done && edges < 100) begin
      if (busy) bc++;
      if (inject && edges == 5) drive(OP_ADD, 1'b0, 24'h000001, 24'h000001);
      if (inject && edges == 6) start = 1'b0;
      step();
      edges++;
    end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".latency"}, 32'(edges), 32'(e.lat));
      chk({e.tag, ".busy_cycles"}, 32'(bc), 32'(e.bcyc));
      chk({e.tag, ".done"}, 32'(done), 32'd1);
      chk({e.tag, ".busy_at_done"}, 32'(busy), 32'd0);
      chk({e.tag, ".result"}, 32'(Result), 32'(e.res));
      chk({e.tag, ".zero"}, 32'(Zero), 32'(e.z));
      chk({e.tag, ".overflow"}, 32'(Overflow), 32'(e.o));
      chk({e.tag, ".illegal"}, 32'(illegal), 32'(e.il));
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic bn,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] r, input logic z, input logic o,
                        input logic il, input int lat, input int bcyc);
    drive(op, bn, a, b);
    push(tag, r, z, o, il, lat, bcyc);
    step();
    start = 1'b0;
    collect(1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.result", 32'(Result), 32'd0);
    chk("rst.zero", 32'(Zero), 32'd0);
    chk("rst.overflow", 32'(Overflow), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.illegal", 32'(illegal), 32'd0);
    reset = 1'b0;
    step();

    // Single-cycle ops
    run_op("add_ovf", OP_ADD, 1'b0, 24'h7FFFFF, 24'h000001, 24'h800000, 1'b0, 1'b1, 1'b0, 0, 0);
    run_op("sub_zero", OP_ADD, 1'b1, 24'h00ABCD, 24'h00ABCD, 24'h000000, 1'b1, 1'b0, 1'b0, 0, 0);
    run_op("sub_ovf", OP_ADD, 1'b1, 24'h800000, 24'h000001, 24'h7FFFFF, 1'b0, 1'b1, 1'b0, 0, 0);
    run_op("slt_neg", OP_SLT, 1'b0, 24'hFFFFFF, 24'h000001, 24'h000001, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op("slt_pos", OP_SLT, 1'b1, 24'h000001, 24'hFFFFFF, 24'h000000, 1'b1, 1'b0, 1'b0, 0, 0);
    run_op("and", OP_AND, 1'b0, 24'hF0F0F0, 24'h3C3C3C, 24'h303030, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op("or", OP_OR, 1'b0, 24'hF0F0F0, 24'h3C3C3C, 24'hFCFCFC, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op("xor", OP_XOR, 1'b0, 24'hF0F0F0, 24'h3C3C3C, 24'hCCCCCC, 1'b0, 1'b0, 1'b0, 0, 0);

    // Back-to-back single-cycle starts
    drive(OP_ADD, 1'b0, 24'h000010, 24'h000020);
    push("b2b_add", 24'h000030, 1'b0, 1'b0, 1'b0, 0, 0);
    step();
    drive(OP_XOR, 1'b0, 24'hFF00FF, 24'h00FFFF);
    push("b2b_xor", 24'hFFFF00, 1'b0, 1'b0, 1'b0, 0, 0);
    collect(1'b0);
    step();
    start = 1'b0;
    collect(1'b0);
    step();
    chk("b2b.done_falls", 32'(done), 32'd0);

    // MUL with an ignored start while busy
    drive(OP_MUL, 1'b0, 24'h001234, 24'h000100);
    push("mul_basic", 24'h123400, 1'b0, 1'b0, 1'b0, W, W);
    step();
    start = 1'b0;
    collect(1'b1);
    dcount = 0;
    repeat (30) begin
      step();
      if (done) dcount++;
    end
    chk("mul_basic.no_extra_done", 32'(dcount), 32'd0);
    chk("mul_basic.result_held", 32'(Result), 32'h123400);

    run_op("mul_ovf", OP_MUL, 1'b0, 24'h800000, 24'h000002, 24'h000000, 1'b1, 1'b1, 1'b0, W, W);

    // Shifts
    run_op("sll_23", OP_SLL, 1'b0, 24'h000001, 24'd23, 24'h800000, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op("sll_24", OP_SLL, 1'b0, 24'h000001, 24'd24, 24'h000000, 1'b1, 1'b0, 1'b0, 0, 0);
    run_op("sll_wrapbits", OP_SLL, 1'b0, 24'h000001, 24'h000021, 24'h000002, 1'b0, 1'b0, 1'b0, 0, 0);

    // Illegal opcodes
    run_op("ill_0111", 4'b0111, 1'b0, 24'h123456, 24'h000001, 24'h000000, 1'b1, 1'b0, 1'b1, 0, 0);
    step();
    chk("ill_0111.illegal_falls", 32'(illegal), 32'd0);
    run_op("ill_1111", 4'b1111, 1'b1, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 1'b1, 1'b0, 1'b1, 0, 0);

    // Signed operands: low half correct, unsigned upper half nonzero
    run_op("mul_signed", OP_MUL, 1'b0, 24'hFFFFFD, 24'h000005, 24'hFFFFF1, 1'b0, 1'b1, 1'b0, W, W);

    // Reset in the middle of a MUL
    drive(OP_MUL, 1'b0, 24'h000010, 24'h000003);
    step();
    start = 1'b0;
    repeat (9) step();
    chk("abort.busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort.result", 32'(Result), 32'd0);
    chk("abort.zero", 32'(Zero), 32'd0);
    chk("abort.overflow", 32'(Overflow), 32'd0);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.illegal", 32'(illegal), 32'd0);
    step();
    reset = 1'b0;
    dcount = 0;
    repeat (40) begin
      step();
      if (done || busy) dcount++;
    end
    chk("abort.no_done", 32'(dcount), 32'd0);

    run_op("add_after_rst", OP_ADD, 1'b0, 24'h000003, 24'h000004, 24'h000007, 1'b0, 1'b0, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
